bus_fabric: RTL

BUS_FABRIC -- requirements
Module: bus_fabric

---
 rtl/bus_fabric_if.sv | 37 +++
 rtl/bus_fabric.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bus_fabric_if.sv
// CPU-side request/response and slave-side broadcast/strobe signals of the bus fabric.
// The fabric takes the slave modport; the environment (CPU plus slaves) takes master.
interface bus_fabric_if #(
   parameter int W  = 32,
   parameter int AW = 16,
   parameter int NS = 4
);
   logic [AW-1:0]   addr;
   logic            rd_en;
   logic            wr_en;
   logic [W-1:0]    wr_data;
   logic [W/8-1:0]  wr_mask;
   logic [W-1:0]    rd_data;
   logic            rd_valid;
   logic            bus_err;
   logic [7:0]      err_count;
   logic            busy;
   logic [AW-1:0]   s_addr;
   logic [W-1:0]    s_wr_data;
   logic [W/8-1:0]  s_wr_mask;
   logic [NS-1:0]   s_rd_en;
   logic [NS-1:0]   s_wr_en;
   logic [NS*W-1:0] s_rd_data;
   logic [NS-1:0]   s_rd_valid;

   modport master (
      output addr, rd_en, wr_en, wr_data, wr_mask, s_rd_data, s_rd_valid,
      input  rd_data, rd_valid, bus_err, err_count, busy,
             s_addr, s_wr_data, s_wr_mask, s_rd_en, s_wr_en
   );

   modport slave (
      input  addr, rd_en, wr_en, wr_data, wr_mask, s_rd_data, s_rd_valid,
      output rd_data, rd_valid, bus_err, err_count, busy,
             s_addr, s_wr_data, s_wr_mask, s_rd_en, s_wr_en
   );
endinterface

// File: rtl/bus_fabric.sv
// Single-master to NS-slave fabric: combinational address decode, posted writes,
// one outstanding read with timeout, error response and saturating error counter.
module bus_fabric #(
   parameter int               W        = 32,
   parameter int               AW       = 16,
   parameter int               NS       = 4,
   parameter logic [NS*AW-1:0] SLV_BASE = '0,
   parameter logic [NS*AW-1:0] SLV_MASK = '0,
   parameter int               TIMEOUT  = 15,
   parameter logic [W-1:0]     ERR_DATA = '1
) (
   input logic         clk,
   input logic         rst_n,
   bus_fabric_if.slave bus
);
   localparam int IW = (NS > 1) ? $clog2(NS) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

   state_t          r_state, w_next;
   logic [IW-1:0]   r_cur;
   logic [CW-1:0]   r_cnt;
   logic [7:0]      r_errcnt;
   logic            r_wr_err;

   logic [NS-1:0]   w_hit;
   logic [IW-1:0]   w_sel;
   logic            w_mapped;
   logic [W-1:0]    w_sdata [NS];
   logic            w_rd_ok, w_rd_err, w_wr_ok, w_wr_err;
   logic            w_rsp, w_tmo, w_bus_err;

   for (genvar i = 0; i < NS; i++) begin : g_slv
      assign w_hit[i]   = (bus.addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW];
      assign w_sdata[i] = bus.s_rd_data[i*W +: W];
   end

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      w_sel    = '0;
      w_mapped = 1'b0;
      for (int i = NS - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_sel    = IW'(i);
            w_mapped = 1'b1;
         end
      end
   end

   assign w_rd_ok  = bus.rd_en & ~bus.wr_en & w_mapped;
   assign w_rd_err = bus.rd_en & (bus.wr_en | ~w_mapped);
   assign w_wr_ok  = bus.wr_en & ~bus.rd_en & w_mapped;
   assign w_wr_err = bus.wr_en & ~bus.rd_en & ~w_mapped;
   assign w_rsp    = bus.s_rd_valid[r_cur];
   assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_rd_ok)       w_next = S_WAIT;
            else if (w_rd_err) w_next = S_ERR;
         end
         // A valid on the timeout cycle takes priority over the timeout.
         S_WAIT: begin
            if (w_rsp)      w_next = S_IDLE;
            else if (w_tmo) w_next = S_ERR;
         end
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.s_rd_en  = '0;
      bus.s_wr_en  = '0;
      bus.rd_valid = 1'b0;
      bus.rd_data  = '0;
      w_bus_err    = r_wr_err;
      case (r_state)
         S_IDLE: begin
            bus.s_rd_en[w_sel] = w_rd_ok & rst_n;
            bus.s_wr_en[w_sel] = w_wr_ok & rst_n;
         end
         S_WAIT: begin
            if (w_rsp) begin
               bus.rd_valid = 1'b1;
               bus.rd_data  = w_sdata[r_cur];
            end
         end
         S_ERR: begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = ERR_DATA;
            w_bus_err    = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.bus_err   = w_bus_err;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.err_count = r_errcnt;
   assign bus.s_addr    = bus.addr;
   assign bus.s_wr_data = bus.wr_data;
   assign bus.s_wr_mask = bus.wr_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur    <= '0;
         r_cnt    <= '0;
         r_errcnt <= '0;
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= (r_state == S_IDLE) & w_wr_err;
         if (r_state == S_IDLE && w_rd_ok) begin
            r_cur <= w_sel;
            r_cnt <= '0;
         end else if (r_state == S_WAIT && !w_rsp && !w_tmo) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_bus_err && r_errcnt != 8'hFF) r_errcnt <= r_errcnt + 8'd1;
      end
   end
endmodule
